// File: rtl/coco_cas_pkg.sv
// Shared state encoding and default tape timing for the CoCo cassette player.
package coco_cas_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int HALF1_DEF  = 186;
  localparam int HALF0_DEF  = 373;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BIT   = 3'd3,
    ST_EOT   = 3'd4
  } cas_state_t;

  function automatic logic is_playing(input cas_state_t st);
    is_playing = (st == ST_FETCH) || (st == ST_WAIT) || (st == ST_BIT);
  endfunction

endpackage

// File: rtl/cas_bit_timer.sv
// Half-cycle down counter paced by q_ce; reports the tick on which a half ends.
module cas_bit_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             q_ce,
  input  logic             freeze,
  output logic             half_end
);

  logic [CNT_W-1:0] count_r;
  logic             tick_s;

  assign tick_s   = q_ce && !freeze;
  assign half_end = tick_s && (count_r == CNT_W'(1));

  // Counter register; a load starts a fresh half and wins over a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (tick_s && (count_r > CNT_W'(1))) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/cas_player.sv
// CoCo cassette player: streams a tape image from memory as a FSK bit-level waveform.
module cas_player
  import coco_cas_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int HALF1  = HALF1_DEF,
  parameter int HALF0  = HALF0_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              q_ce,
  input  logic              motor,
  input  logic              rewind,
  input  logic              loop,
  input  logic              load_done,
  input  logic [ADDR_W:0]   tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              dout,
  output logic              playing,
  output logic              eot,
  output logic [ADDR_W-1:0] pos
);

  localparam int HMAX   = (HALF1 > HALF0) ? HALF1 : HALF0;
  localparam int CNT_W  = $clog2(HMAX + 1);
  localparam int WAIT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] H1 = CNT_W'(HALF1);
  localparam logic [CNT_W-1:0] H0 = CNT_W'(HALF0);

  function automatic logic [CNT_W-1:0] half_len(input logic b);
    half_len = b ? H1 : H0;
  endfunction

  cas_state_t        state_r, state_nxt;
  logic [ADDR_W-1:0] pos_r, pos_nxt;
  logic [ADDR_W:0]   len_r, len_nxt;
  logic [7:0]        shift_r, shift_nxt;
  logic [2:0]        bit_idx_r, bit_idx_nxt;
  logic              phase_r, phase_nxt;
  logic [WAIT_W-1:0] wait_cnt_r, wait_nxt;
  logic              dout_r, dout_nxt;
  logic              eot_r, playing_r, mem_rd_r;
  logic [ADDR_W-1:0] mem_addr_r;

  logic              tmr_load_s, tmr_clear_s, half_end_s, freeze_s;
  logic [CNT_W-1:0]  tmr_val_s;

  // Outside BIT, and while a rewind/load is landing, q_ce must not advance the waveform.
  assign freeze_s = !motor || (state_r != ST_BIT) || rewind || load_done;

  cas_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear_s),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .q_ce     (q_ce),
    .freeze   (freeze_s),
    .half_end (half_end_s)
  );

  // Next-state and datapath decode; rewind/load_done override whatever is in flight.
  always_comb begin
    state_nxt   = state_r;
    pos_nxt     = pos_r;
    len_nxt     = len_r;
    shift_nxt   = shift_r;
    bit_idx_nxt = bit_idx_r;
    phase_nxt   = phase_r;
    wait_nxt    = wait_cnt_r;
    dout_nxt    = dout_r;
    tmr_load_s  = 1'b0;
    tmr_clear_s = 1'b0;
    tmr_val_s   = half_len(shift_r[0]);
    if (load_done || rewind) begin
      if (load_done) begin
        len_nxt = tape_len;
      end else begin
        len_nxt = len_r;
      end
      state_nxt   = ST_IDLE;
      pos_nxt     = {ADDR_W{1'b0}};
      dout_nxt    = 1'b0;
      phase_nxt   = 1'b0;
      bit_idx_nxt = 3'd0;
      wait_nxt    = {WAIT_W{1'b0}};
      tmr_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!motor) begin
            state_nxt = ST_IDLE;
          end else if (len_r == (ADDR_W+1)'(0)) begin
            state_nxt = ST_EOT;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_nxt = ST_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
        ST_WAIT: begin
          if (wait_cnt_r >= WAIT_W'(RD_LAT)) begin
            shift_nxt   = mem_data;
            bit_idx_nxt = 3'd0;
            phase_nxt   = 1'b0;
            dout_nxt    = 1'b1;
            tmr_load_s  = 1'b1;
            tmr_val_s   = half_len(mem_data[0]);
            wait_nxt    = {WAIT_W{1'b0}};
            state_nxt   = ST_BIT;
          end else begin
            wait_nxt = wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_BIT: begin
          if (!half_end_s) begin
            state_nxt = ST_BIT;
          end else if (!phase_r) begin
            phase_nxt  = 1'b1;
            dout_nxt   = 1'b0;
            tmr_load_s = 1'b1;
            tmr_val_s  = half_len(shift_r[0]);
          end else if (bit_idx_r != 3'd7) begin
            bit_idx_nxt = bit_idx_r + 3'd1;
            shift_nxt   = {1'b0, shift_r[7:1]};
            phase_nxt   = 1'b0;
            dout_nxt    = 1'b1;
            tmr_load_s  = 1'b1;
            tmr_val_s   = half_len(shift_r[1]);
          end else begin
            phase_nxt = 1'b0;
            dout_nxt  = 1'b0;
            // pos+1 < len, widened so a full 2^ADDR_W image compares correctly
            if (({1'b0, pos_r} + (ADDR_W+1)'(1)) < len_r) begin
              pos_nxt   = pos_r + ADDR_W'(1);
              state_nxt = ST_FETCH;
            end else if (loop) begin
              pos_nxt   = {ADDR_W{1'b0}};
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_EOT;
            end
          end
        end
        ST_EOT: begin
          dout_nxt  = 1'b0;
          state_nxt = ST_EOT;
        end
        default: begin
          dout_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath and output registers; flags are decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r      <= {ADDR_W{1'b0}};
      len_r      <= {(ADDR_W+1){1'b0}};
      shift_r    <= 8'd0;
      bit_idx_r  <= 3'd0;
      phase_r    <= 1'b0;
      wait_cnt_r <= {WAIT_W{1'b0}};
      dout_r     <= 1'b0;
      eot_r      <= 1'b0;
      playing_r  <= 1'b0;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
    end else begin
      pos_r      <= pos_nxt;
      len_r      <= len_nxt;
      shift_r    <= shift_nxt;
      bit_idx_r  <= bit_idx_nxt;
      phase_r    <= phase_nxt;
      wait_cnt_r <= wait_nxt;
      dout_r     <= dout_nxt;
      eot_r      <= (state_nxt == ST_EOT);
      playing_r  <= is_playing(state_nxt);
      mem_rd_r   <= (state_nxt == ST_FETCH);
      mem_addr_r <= (state_nxt == ST_FETCH) ? pos_nxt : mem_addr_r;
    end
  end

  assign mem_addr = mem_addr_r;
  assign mem_rd   = mem_rd_r;
  assign dout     = dout_r;
  assign playing  = playing_r;
  assign eot      = eot_r;
  assign pos      = pos_r;

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player: byte-pattern table plus hand-written pause/rewind/reset sequences.
module tb_cas_player;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset, q_ce, motor, rewind, loop, load_done;
  logic [ADDR_W:0]   tape_len;
  logic [ADDR_W-1:0] mem_addr, pos;
  logic              mem_rd, dout, playing, eot;
  logic [7:0]        mem_data;

  cas_player #(.ADDR_W(ADDR_W), .HALF1(186), .HALF0(373), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .q_ce(q_ce), .motor(motor), .rewind(rewind), .loop(loop),
    .load_done(load_done), .tape_len(tape_len), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .dout(dout), .playing(playing), .eot(eot), .pos(pos)
  );

  always #5 clk = ~clk;

  // Tape memory with RD_LAT-cycle read latency.
  logic [7:0]        mem [0:15];
  logic [ADDR_W-1:0] addr_pipe [0:RD_LAT-1];
  int                rd_count = 0;
  always @(posedge clk) begin
    addr_pipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    if (mem_rd) rd_count <= rd_count + 1;
  end
  assign mem_data = mem[addr_pipe[RD_LAT-1][3:0]];

  int qce_div = 1;
  initial begin
    int k;
    k = 0;
    q_ce = 1'b0;
    forever begin
      @(negedge clk);
      k++;
      q_ce = ((k % qce_div) == 0);
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
  endtask

  // Cycles dout stays at lvl (stops at end of tape); caller sits on a negedge.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (dout === lvl && eot !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_dout_high(input string nm);
    int n;
    n = 0;
    while (dout !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(nm, dout, 1);
  endtask

  task automatic play_byte(output int first, output int last, output int hs, output int ls);
    int n;
    first = 0; last = 0; hs = 0; ls = 0;
    for (int b = 0; b < 8; b++) begin
      run_len(1'b1, n);
      if (b == 0) first = n;
      if (b == 7) last = n;
      hs += n;
      run_len(1'b0, n);
      ls += n;
    end
  endtask

  task automatic load_img(input int len);
    load_done = 1'b1;
    tape_len  = (ADDR_W+1)'(len);
    @(negedge clk);
    load_done = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    int         first;
    int         last;
    int         sum;
  } vec_t;
  vec_t vecs [0:4];

  initial begin
    int f, l, hs, ls, n, snap;
    vecs[0] = '{8'h01, 186, 373, 2797};
    vecs[1] = '{8'hFF, 186, 186, 1488};
    vecs[2] = '{8'h00, 373, 373, 2984};
    vecs[3] = '{8'h80, 373, 186, 2797};
    vecs[4] = '{8'hA5, 186, 186, 2236};

    reset = 1'b1; motor = 1'b0; rewind = 1'b0; loop = 1'b0; load_done = 1'b0;
    tape_len = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset dout", dout, 0);
    check("reset eot", eot, 0);
    check("reset playing", playing, 0);
    check("reset mem_rd", mem_rd, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset pos", pos, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single-byte images from the table
    for (int i = 0; i < 5; i++) begin
      mem[0] = vecs[i].data;
      load_img(1);
      motor = 1'b1;
      wait_dout_high($sformatf("vec%0d start", i));
      play_byte(f, l, hs, ls);
      check($sformatf("vec%0d first half", i), f, vecs[i].first);
      check($sformatf("vec%0d last half", i), l, vecs[i].last);
      check($sformatf("vec%0d high sum", i), hs, vecs[i].sum);
      check($sformatf("vec%0d low sum", i), ls, vecs[i].sum);
      check($sformatf("vec%0d eot", i), eot, 1);
      check($sformatf("vec%0d eot dout", i), dout, 0);
      motor = 1'b0;
      @(negedge clk);
    end

    // Loop over a two-byte image
    mem[0] = 8'hFF; mem[1] = 8'h00;
    loop = 1'b1;
    load_img(2);
    motor = 1'b1;
    wait_dout_high("loop start");
    play_byte(f, l, hs, ls);
    check("loop b0 high", hs, 1488);
    check("loop pos1", pos, 1);
    play_byte(f, l, hs, ls);
    check("loop b1 high", hs, 2984);
    check_rng("loop b1 low+gap", ls, 2985, 2988);
    check("loop wrap pos", pos, 0);
    check("loop wrap eot", eot, 0);
    play_byte(f, l, hs, ls);
    check("loop pass2 high", hs, 1488);
    loop = 1'b0;
    motor = 1'b0;

    // Motor pause after 100 ticks of the first half
    mem[0] = 8'h01;
    load_img(1);
    motor = 1'b1;
    wait_dout_high("pause start");
    repeat (100) @(negedge clk);
    motor = 1'b0;
    repeat (500) @(negedge clk);
    check("pause dout", dout, 1);
    check("pause playing", playing, 1);
    motor = 1'b1;
    run_len(1'b1, n);
    check("pause remaining high", n, 86);
    run_len(1'b0, n);
    check("pause low", n, 186);
    motor = 1'b0;

    // Waveform advances only on q_ce
    qce_div = 3;
    mem[0] = 8'hFF;
    load_img(1);
    motor = 1'b1;
    wait_dout_high("qce3 start");
    run_len(1'b1, n);
    check_rng("qce3 high", n, 556, 558);
    motor = 1'b0;
    qce_div = 1;

    // Rewind mid-byte at pos 5
    for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
    load_img(8);
    motor = 1'b1;
    n = 0;
    while (pos != 16'd5 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("rewind reach pos5", pos, 5);
    repeat (200) @(negedge clk);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    check("rewind pos", pos, 0);
    check("rewind dout", dout, 0);
    check("rewind idle", playing, 0);
    @(negedge clk);
    check("rewind refetch rd", mem_rd, 1);
    check("rewind refetch addr", mem_addr, 0);

    // Empty image with motor on
    load_img(0);
    snap = rd_count;
    repeat (4) @(negedge clk);
    check("empty eot", eot, 1);
    check("empty no reads", rd_count - snap, 0);
    check("empty playing", playing, 0);

    // Rewind and load_done together
    motor = 1'b0;
    rewind = 1'b1; load_done = 1'b1; tape_len = (ADDR_W+1)'(3);
    @(negedge clk);
    rewind = 1'b0; load_done = 1'b0;
    check("coinc pos", pos, 0);
    check("coinc eot", eot, 0);
    motor = 1'b1;
    n = 0;
    while (eot !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("coinc eot reached", eot, 1);
    check("coinc last pos", pos, 2);

    // Reset during WAIT of byte 1, with a competing load_done
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    n = 0;
    while (!(mem_rd === 1'b1 && mem_addr == 16'd1) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("rst reach fetch1", mem_addr, 1);
    @(negedge clk);
    reset = 1'b1; load_done = 1'b1; tape_len = (ADDR_W+1)'(5);
    @(negedge clk);
    load_done = 1'b0;
    check("rst dout", dout, 0);
    check("rst eot", eot, 0);
    check("rst playing", playing, 0);
    check("rst mem_rd", mem_rd, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst pos", pos, 0);
    reset = 1'b0;
    snap = rd_count;
    repeat (4) @(negedge clk);
    check("rst len cleared eot", eot, 1);
    check("rst len cleared reads", rd_count - snap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cas_player.md
CAS_PLAYER -- requirements
Module: cas_player

Interface
REQ-001 Parameter ADDR_W, default 16: tape image address width.
REQ-002 Parameter HALF1, default 186: q_ce ticks per half-cycle of a '1' bit (2400 Hz).
REQ-003 Parameter HALF0, default 373: q_ce ticks per half-cycle of a '0' bit (1200 Hz).
REQ-004 Parameter RD_LAT, default 2: clk cycles from mem_rd to mem_data valid.
REQ-005 clk  in  1  system clock; the single clock of the block.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 q_ce  in  1  one-cycle strobe at the CoCo Q rate; sole timebase for the waveform.
REQ-008 motor  in  1  cassette relay level; 1 = play.
REQ-009 rewind  in  1  one-cycle pulse; return to tape start.
REQ-010 loop  in  1  1 = wrap to start at end of tape instead of stopping.
REQ-011 load_done  in  1  one-cycle pulse; a new image has been written to memory.
REQ-012 tape_len  in  ADDR_W+1  image length in bytes; sampled on load_done.
REQ-013 mem_addr  out  ADDR_W  byte address to tape memory.
REQ-014 mem_rd  out  1  one-cycle read strobe.
REQ-015 mem_data  in  8  read data, valid RD_LAT cycles after mem_rd.
REQ-016 dout  out  1  cassette bit-level output.
REQ-017 playing  out  1  1 while the FSM is in FETCH, WAIT or BIT.
REQ-018 eot  out  1  end-of-tape flag.
REQ-019 pos  out  ADDR_W  index of the byte currently playing.

Function
REQ-020 The FSM SHALL have exactly five states: IDLE, FETCH, WAIT, BIT, EOT.
REQ-021 IDLE: on motor=1, the block SHALL go to EOT if len=0, else to FETCH.
REQ-022 FETCH: mem_rd=1 and mem_addr=pos for one cycle, then WAIT.
REQ-023 WAIT: after RD_LAT cycles, capture mem_data into an 8-bit shift register, clear bit index to 0, set dout=1, load the half counter, enter BIT.
REQ-024 BIT: each bit is one full cycle, dout=1 for one half then dout=0 for one half, LSB first; the half length SHALL be HALF1 if the current bit is 1, else HALF0.
REQ-025 The half counter SHALL decrement only on q_ce; the half ends at the q_ce where the count reaches 1.
REQ-026 After bit 7: if pos<len-1, pos increments and the FSM goes to FETCH; if pos=len-1 and loop=1, pos goes to 0 and the FSM goes to FETCH; otherwise the FSM goes to EOT.
REQ-027 Inter-byte gap SHALL be at most RD_LAT+2 clk cycles, with no q_ce tick consumed by the gap.
REQ-028 EOT: dout=0, eot=1; the block stays in EOT until rewind, load_done or reset.
REQ-029 When motor=0 in BIT, the half counter, bit index and dout SHALL freeze, and play resumes in place when motor returns to 1.
REQ-030 When motor falls in FETCH or WAIT, the fetch SHALL complete and the FSM then holds at entry to BIT.
REQ-031 rewind SHALL force pos=0, eot=0, dout=0, state IDLE next cycle, overriding any in-flight fetch.
REQ-032 load_done SHALL latch tape_len into len and also perform the rewind action.
REQ-033 When rewind and load_done coincide, load_done SHALL take effect.
REQ-034 q_ce coincident with rewind or load_done SHALL be ignored.
REQ-035 len SHALL be ADDR_W+1 bits so that a full 2^ADDR_W image is representable; len=0 means no tape.

Reset
REQ-036 reset SHALL set state=IDLE, pos=0, len=0, dout=0, eot=0, mem_rd=0, mem_addr=0, playing=0, shift register and counters =0.
REQ-037 reset SHALL have priority over rewind, load_done and motor.
REQ-038 All outputs SHALL be registered.

Structure
REQ-039 The state enum and default timing constants SHALL live in shared package coco_cas_pkg.
REQ-040 One sub-module, cas_bit_timer (half counter with q_ce enable and freeze input), SHALL be instantiated; all else is in cas_player.

Verification
REQ-041 The bench SHALL cover the following directed scenarios:
- Single-byte play: len=1, byte 0x01, motor=1, q_ce every cycle -> dout high 186, low 186, then 7x(373 high/373 low); then eot=1, dout=0.
- Loop: len=2, loop=1, bytes 0xFF,0x00 -> after byte 1, pos=0, no EOT, second pass identical.
- Motor pause: drop motor at tick 100 of the first half -> dout holds, counter frozen; re-raise -> remaining 86 (or 273) ticks complete.
- Rewind mid-byte at pos=5 -> next cycle pos=0, dout=0, state IDLE; motor=1 -> fetch from address 0.
- load_done with tape_len=0 and motor=1 -> eot=1, mem_rd never asserted.
- Simultaneous rewind and load_done with tape_len=3 -> len=3, pos=0; reset during WAIT -> all outputs 0 next cycle.
